// File: rtl/aer_event_encoder.sv
// AER event encoder: turns one-hot arbiter grants into {ts, x, y, pol} words
// and buffers them in a first-word-fall-through FIFO on a valid/ready stream.
module aer_event_encoder #(
    parameter int unsigned ROWS       = 8,
    parameter int unsigned COLS       = 8,
    parameter int unsigned TS_WIDTH   = 32,
    parameter int unsigned FIFO_DEPTH = 16,
    localparam int unsigned X_W       = $clog2(ROWS),
    localparam int unsigned Y_W       = $clog2(COLS),
    localparam int unsigned DW        = TS_WIDTH + X_W + Y_W + 1,
    localparam int unsigned FILL_W    = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic                           enable_i,
    input  logic [ROWS-1:0][COLS-1:0]      gnt_i,
    input  logic                           polarity_i,
    input  logic [TS_WIDTH-1:0]            timestamp_i,
    input  logic                           clear_i,
    output logic                           m_valid_o,
    input  logic                           m_ready_i,
    output logic [DW-1:0]                  m_data_o,
    output logic [FILL_W-1:0]              fill_o,
    output logic                           overflow_o,
    output logic                           grant_err_o,
    output logic [15:0]                    drop_cnt_o
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned N  = ROWS * COLS;

    logic [N-1:0]   w_gnt_flat;
    logic [N-1:0]   r_gnt_q;
    logic           w_any;
    logic           w_onehot;
    logic           w_multi;
    logic [X_W-1:0] w_x;
    logic [Y_W-1:0] w_y;
    logic           w_evt;
    logic           w_full;
    logic           w_empty;
    logic           w_pop;
    logic           w_push;
    logic           w_drop;
    logic           w_gerr;
    logic [DW-1:0]  w_word;

    logic [PW-1:0]  r_wr_ptr;
    logic [PW-1:0]  r_rd_ptr;
    logic [DW-1:0]  r_mem [FIFO_DEPTH];
    logic           r_overflow;
    logic           r_grant_err;
    logic [15:0]    r_drop_cnt;

    assign w_gnt_flat = gnt_i;
    assign w_any      = |w_gnt_flat;
    // Clearing the lowest set bit leaves zero only for a single set bit.
    assign w_onehot   = w_any && ((w_gnt_flat & (w_gnt_flat - N'(1))) == '0);
    assign w_multi    = w_any && !w_onehot;

    // Row/column encoder; OR-reduction is exact because only one-hot grants are used.
    always_comb begin
        w_x = '0;
        w_y = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if (gnt_i[r][c]) begin
                    w_x = w_x | X_W'(r);
                    w_y = w_y | Y_W'(c);
                end
            end
        end
    end

    assign w_evt   = enable_i && w_onehot && (w_gnt_flat != r_gnt_q);
    assign w_gerr  = enable_i && w_multi;
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
    assign w_pop   = !w_empty && m_ready_i;
    // A pop in the same cycle frees the slot, so a push at full is still accepted.
    assign w_push  = w_evt && (!w_full || w_pop);
    assign w_drop  = w_evt && w_full && !w_pop;
    assign w_word  = {timestamp_i, w_x, w_y, polarity_i};

    // Previous-grant register for edge detection, independent of enable_i.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_gnt_q <= '0;
        end else begin
            r_gnt_q <= w_gnt_flat;
        end
    end

    // FIFO storage; contents need no reset because the read side is gated by empty.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= w_word;
        end
    end

    // Read/write pointers with an extra MSB to tell full from empty.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
        end
    end

    // Sticky error flags and saturating drop counter; a same-cycle drop beats clear.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_overflow  <= 1'b0;
            r_grant_err <= 1'b0;
            r_drop_cnt  <= '0;
        end else if (clear_i) begin
            r_overflow  <= w_drop;
            r_grant_err <= w_gerr;
            r_drop_cnt  <= w_drop ? 16'd1 : 16'd0;
        end else begin
            r_overflow  <= r_overflow | w_drop;
            r_grant_err <= r_grant_err | w_gerr;
            if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
                r_drop_cnt <= r_drop_cnt + 16'd1;
            end
        end
    end

    assign m_valid_o   = !w_empty;
    assign m_data_o    = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
    assign fill_o      = r_wr_ptr - r_rd_ptr;
    assign overflow_o  = r_overflow;
    assign grant_err_o = r_grant_err;
    assign drop_cnt_o  = r_drop_cnt;

endmodule

// File: tb/tb_aer_event_encoder.sv
// Self-checking bench for aer_event_encoder: a negedge scoreboard model predicts
// every accepted word; scenario tasks check status outputs against fixed values.
module tb_aer_event_encoder;

    localparam int DW = 39;

    logic              clk = 1'b0;
    logic              reset_i;
    logic              enable_i;
    logic [7:0][7:0]   gnt_i;
    logic              polarity_i;
    logic [31:0]       timestamp_i;
    logic              clear_i;
    logic              m_valid_o;
    logic              m_ready_i;
    logic [DW-1:0]     m_data_o;
    logic [4:0]        fill_o;
    logic              overflow_o;
    logic              grant_err_o;
    logic [15:0]       drop_cnt_o;

    int                n_checks = 0;
    int                n_fails  = 0;
    logic [DW-1:0]     sb[$];
    logic [63:0]       m_prev = '0;
    logic              hold_v = 1'b0;
    logic [DW-1:0]     hold_d;

    aer_event_encoder dut (
        .clk_i       (clk),
        .reset_i     (reset_i),
        .enable_i    (enable_i),
        .gnt_i       (gnt_i),
        .polarity_i  (polarity_i),
        .timestamp_i (timestamp_i),
        .clear_i     (clear_i),
        .m_valid_o   (m_valid_o),
        .m_ready_i   (m_ready_i),
        .m_data_o    (m_data_o),
        .fill_o      (fill_o),
        .overflow_o  (overflow_o),
        .grant_err_o (grant_err_o),
        .drop_cnt_o  (drop_cnt_o)
    );

    always #5 clk = ~clk;

    // Scoreboard: check the output side, then predict what the coming edge captures.
    always @(negedge clk) begin
        int          sz;
        logic        pop_m;
        logic        evt;
        logic [2:0]  ex;
        logic [2:0]  ey;
        logic [DW-1:0] exp_w;
        if (!reset_i) begin
            sz    = sb.size();
            pop_m = (sz > 0) && m_ready_i;
            n_checks++;
            if (m_valid_o !== (sz > 0)) begin
                n_fails++;
                $display("FAIL sb_valid: m_valid_o=%b expected %b", m_valid_o, sz > 0);
            end
            if (hold_v) begin
                n_checks++;
                if (m_valid_o !== 1'b1 || m_data_o !== hold_d) begin
                    n_fails++;
                    $display("FAIL stall_stable: valid=%b data=%h expected 1/%h",
                             m_valid_o, m_data_o, hold_d);
                end
            end
            if (m_valid_o === 1'b1 && m_ready_i) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_fails++;
                    $display("FAIL sb_extra: unexpected word %h", m_data_o);
                end else begin
                    exp_w = sb.pop_front();
                    if (m_data_o !== exp_w) begin
                        n_fails++;
                        $display("FAIL sb_word: got %h expected %h", m_data_o, exp_w);
                    end
                end
            end
            hold_v = (m_valid_o === 1'b1) && !m_ready_i;
            hold_d = m_data_o;
            evt = enable_i && ($countones(gnt_i) == 1) && (gnt_i != m_prev);
            if (evt && ((sz < 16) || pop_m)) begin
                ex = '0;
                ey = '0;
                for (int r = 0; r < 8; r++) begin
                    for (int c = 0; c < 8; c++) begin
                        if (gnt_i[r][c]) begin
                            ex = 3'(r);
                            ey = 3'(c);
                        end
                    end
                end
                sb.push_back({timestamp_i, ex, ey, polarity_i});
            end
            m_prev = gnt_i;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_gnt(input int r, input int c);
        gnt_i = '0;
        gnt_i[r][c] = 1'b1;
    endtask

    task automatic test_reset();
        #3;
        n_checks++;
        if (m_valid_o !== 1'b0) begin n_fails++; $display("FAIL rst_valid: got %b expected 0", m_valid_o); end
        n_checks++;
        if (m_data_o !== '0) begin n_fails++; $display("FAIL rst_data: got %h expected 0", m_data_o); end
        n_checks++;
        if (fill_o !== 5'd0) begin n_fails++; $display("FAIL rst_fill: got %0d expected 0", fill_o); end
        n_checks++;
        if (overflow_o !== 1'b0 || grant_err_o !== 1'b0) begin
            n_fails++;
            $display("FAIL rst_flags: got ovf=%b gerr=%b expected 0/0", overflow_o, grant_err_o);
        end
        n_checks++;
        if (drop_cnt_o !== 16'd0) begin n_fails++; $display("FAIL rst_drop: got %0d expected 0", drop_cnt_o); end
        tick();
        reset_i = 1'b0;
        tick();
    endtask

    task automatic test_single();
        m_ready_i = 1'b1;
        enable_i = 1'b1;
        set_gnt(3, 5);
        polarity_i = 1'b1;
        timestamp_i = 32'h100;
        tick();
        n_checks++;
        if (m_valid_o !== 1'b1 || m_data_o !== {32'h100, 3'd3, 3'd5, 1'b1}) begin
            n_fails++;
            $display("FAIL single_word: valid=%b data=%h expected 1/%h", m_valid_o, m_data_o,
                     {32'h100, 3'd3, 3'd5, 1'b1});
        end
        for (int i = 1; i < 4; i++) begin
            timestamp_i = 32'h100 + 32'(i);
            polarity_i = 1'b0;
            tick();
        end
        gnt_i = '0;
        repeat (3) tick();
        n_checks++;
        if (fill_o !== 5'd0 || sb.size() != 0) begin
            n_fails++;
            $display("FAIL single_drain: fill=%0d pending=%0d expected 0/0", fill_o, sb.size());
        end
    endtask

    task automatic test_back_to_back();
        timestamp_i = 32'h300;
        set_gnt(0, 0);
        tick();
        timestamp_i = 32'h301;
        polarity_i = 1'b1;
        set_gnt(7, 7);
        tick();
        timestamp_i = 32'h302;
        polarity_i = 1'b0;
        set_gnt(2, 1);
        tick();
        gnt_i = '0;
        repeat (4) tick();
        n_checks++;
        if (drop_cnt_o !== 16'd0 || overflow_o !== 1'b0) begin
            n_fails++;
            $display("FAIL b2b_nodrop: drop=%0d ovf=%b expected 0/0", drop_cnt_o, overflow_o);
        end
        n_checks++;
        if (fill_o !== 5'd0 || sb.size() != 0) begin
            n_fails++;
            $display("FAIL b2b_drain: fill=%0d pending=%0d expected 0/0", fill_o, sb.size());
        end
    endtask

    task automatic test_overflow();
        m_ready_i = 1'b0;
        for (int i = 0; i < 18; i++) begin
            set_gnt(i / 8, i % 8);
            timestamp_i = 32'h200 + 32'(i);
            polarity_i = i[0];
            tick();
        end
        gnt_i = '0;
        tick();
        n_checks++;
        if (fill_o !== 5'd16) begin n_fails++; $display("FAIL ovf_fill: got %0d expected 16", fill_o); end
        n_checks++;
        if (overflow_o !== 1'b1) begin n_fails++; $display("FAIL ovf_flag: got %b expected 1", overflow_o); end
        n_checks++;
        if (drop_cnt_o !== 16'd2) begin n_fails++; $display("FAIL ovf_cnt: got %0d expected 2", drop_cnt_o); end
        m_ready_i = 1'b1;
        repeat (18) tick();
        n_checks++;
        if (fill_o !== 5'd0 || sb.size() != 0) begin
            n_fails++;
            $display("FAIL ovf_drain: fill=%0d pending=%0d expected 0/0", fill_o, sb.size());
        end
    endtask

    task automatic test_full_pop();
        m_ready_i = 1'b0;
        for (int i = 0; i < 16; i++) begin
            set_gnt(i / 8, i % 8);
            timestamp_i = 32'h400 + 32'(i);
            tick();
        end
        gnt_i = '0;
        tick();
        n_checks++;
        if (fill_o !== 5'd16) begin n_fails++; $display("FAIL fp_full: got %0d expected 16", fill_o); end
        m_ready_i = 1'b1;
        set_gnt(5, 6);
        timestamp_i = 32'h4AA;
        tick();
        n_checks++;
        if (fill_o !== 5'd16) begin n_fails++; $display("FAIL fp_fill: got %0d expected 16", fill_o); end
        n_checks++;
        if (drop_cnt_o !== 16'd2) begin n_fails++; $display("FAIL fp_cnt: got %0d expected 2", drop_cnt_o); end
        gnt_i = '0;
        repeat (18) tick();
        n_checks++;
        if (fill_o !== 5'd0 || sb.size() != 0) begin
            n_fails++;
            $display("FAIL fp_drain: fill=%0d pending=%0d expected 0/0", fill_o, sb.size());
        end
    endtask

    task automatic test_malformed();
        n_checks++;
        if (grant_err_o !== 1'b0) begin n_fails++; $display("FAIL mal_pre: got %b expected 0", grant_err_o); end
        gnt_i = '0;
        gnt_i[1][1] = 1'b1;
        gnt_i[4][2] = 1'b1;
        tick();
        gnt_i = '0;
        n_checks++;
        if (grant_err_o !== 1'b1) begin n_fails++; $display("FAIL mal_err: got %b expected 1", grant_err_o); end
        n_checks++;
        if (fill_o !== 5'd0 || m_valid_o !== 1'b0) begin
            n_fails++;
            $display("FAIL mal_nopush: fill=%0d valid=%b expected 0/0", fill_o, m_valid_o);
        end
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        n_checks++;
        if (grant_err_o !== 1'b0 || overflow_o !== 1'b0 || drop_cnt_o !== 16'd0) begin
            n_fails++;
            $display("FAIL mal_clear: gerr=%b ovf=%b drop=%0d expected 0/0/0",
                     grant_err_o, overflow_o, drop_cnt_o);
        end
    endtask

    task automatic test_disable();
        enable_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_gnt(6, i);
            tick();
        end
        gnt_i[2][2] = 1'b1;
        tick();
        gnt_i = '0;
        tick();
        n_checks++;
        if (fill_o !== 5'd0 || m_valid_o !== 1'b0 || grant_err_o !== 1'b0) begin
            n_fails++;
            $display("FAIL dis_idle: fill=%0d valid=%b gerr=%b expected 0/0/0",
                     fill_o, m_valid_o, grant_err_o);
        end
        enable_i = 1'b1;
    endtask

    task automatic test_clear_vs_drop();
        m_ready_i = 1'b0;
        for (int i = 0; i < 17; i++) begin
            set_gnt(i / 8, i % 8);
            timestamp_i = 32'h500 + 32'(i);
            clear_i = (i == 16);
            tick();
        end
        clear_i = 1'b0;
        gnt_i = '0;
        n_checks++;
        if (overflow_o !== 1'b1 || drop_cnt_o !== 16'd1) begin
            n_fails++;
            $display("FAIL cvd_flags: ovf=%b drop=%0d expected 1/1", overflow_o, drop_cnt_o);
        end
        m_ready_i = 1'b1;
        repeat (18) tick();
        n_checks++;
        if (fill_o !== 5'd0 || sb.size() != 0) begin
            n_fails++;
            $display("FAIL cvd_drain: fill=%0d pending=%0d expected 0/0", fill_o, sb.size());
        end
    endtask

    task automatic test_reset_mid();
        m_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set_gnt(i, 3);
            timestamp_i = 32'h600 + 32'(i);
            tick();
        end
        n_checks++;
        if (fill_o !== 5'd5) begin n_fails++; $display("FAIL rm_fill5: got %0d expected 5", fill_o); end
        #1;
        reset_i = 1'b1;
        #1;
        n_checks++;
        if (m_valid_o !== 1'b0 || fill_o !== 5'd0 || m_data_o !== '0) begin
            n_fails++;
            $display("FAIL rm_async: valid=%b fill=%0d data=%h expected 0/0/0",
                     m_valid_o, fill_o, m_data_o);
        end
        sb.delete();
        m_prev = '0;
        hold_v = 1'b0;
        m_ready_i = 1'b1;
        tick();
        tick();
        reset_i = 1'b0;
        timestamp_i = 32'h6FF;
        tick();
        n_checks++;
        if (fill_o !== 5'd1 || m_data_o !== {32'h6FF, 3'd4, 3'd3, polarity_i}) begin
            n_fails++;
            $display("FAIL rm_reevt: fill=%0d data=%h expected 1/%h", fill_o, m_data_o,
                     {32'h6FF, 3'd4, 3'd3, polarity_i});
        end
        repeat (3) tick();
        gnt_i = '0;
        tick();
        n_checks++;
        if (fill_o !== 5'd0 || sb.size() != 0) begin
            n_fails++;
            $display("FAIL rm_single: fill=%0d pending=%0d expected 0/0", fill_o, sb.size());
        end
    endtask

    initial begin
        reset_i     = 1'b1;
        enable_i    = 1'b0;
        gnt_i       = '0;
        polarity_i  = 1'b0;
        timestamp_i = '0;
        clear_i     = 1'b0;
        m_ready_i   = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_full_pop();
        test_malformed();
        test_disable();
        test_clear_vs_drop();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
